// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: first-word-fall-through,
// valid/ready output, fill level, sticky overflow and synchronous flush.
// Ports: clk_int, uart_reset (async, active-low), rx_data/rx_valid (in),
//   out_data/out_valid/out_ready (consumer), level, overflow,
//   clr_overflow, flush, rts_n (only with UART_RX_FIFO_RTS_EN).
// Optional feature macro: UART_RX_FIFO_RTS_EN (registered rts_n flow control).
module uart_rx_fifo #(
  parameter int DEPTH_LOG2    = 4,
  parameter int RTS_THRESHOLD = 12
) (
  input  logic                  clk_int,
  input  logic                  uart_reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clr_overflow,
  input  logic                  flush
`ifdef UART_RX_FIFO_RTS_EN
  ,
  output logic                  rts_n
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LP_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] LP_PINC = (DEPTH_LOG2)'(1);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [DEPTH_LOG2:0]   w_level_nxt;
  logic                  r_overflow;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_wr;

  assign w_full    = (r_level == LP_FULL);
  assign out_valid = (r_level != '0);
  assign w_pop     = out_valid & out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign w_push    = rx_valid & (~w_full | w_pop);
  // A byte lost to flush is not an overflow.
  assign w_drop    = rx_valid & w_full & ~w_pop & ~flush;
  assign w_wr      = w_push & ~flush;

  assign level     = r_level;
  assign overflow  = r_overflow;
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : 8'h00;

  always_comb begin
    w_level_nxt = r_level;
    if (flush)
      w_level_nxt = '0;
    else if (w_push & ~w_pop)
      w_level_nxt = r_level + LP_ONE;
    else if (w_pop & ~w_push)
      w_level_nxt = r_level - LP_ONE;
  end

  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + LP_PINC;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PINC;
      end
      if (w_drop)
        r_overflow <= 1'b1;
      else if (clr_overflow)
        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_int) begin
    if (w_wr) r_mem[r_wr_ptr] <= rx_data;
  end

`ifdef UART_RX_FIFO_RTS_EN
  localparam logic [DEPTH_LOG2:0] LP_RTS = (DEPTH_LOG2+1)'(RTS_THRESHOLD);

  logic r_rts_n;

  // Tracks next-cycle level so rts_n moves on the same edge as level.
  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset)
      r_rts_n <= 1'b0;
    else
      r_rts_n <= (w_level_nxt >= LP_RTS);
  end

  assign rts_n = r_rts_n;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized + directed bench for uart_rx_fifo against a queue model.
// Ports: none (top-level bench).
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int RTS_TH = 12;

  logic       clk_int;
  logic       uart_reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
  logic       overflow;
  logic       clr_overflow;
  logic       flush;
`ifdef UART_RX_FIFO_RTS_EN
  logic       rts_n;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q[$];
  bit         m_ovf;

  uart_rx_fifo #(
    .DEPTH_LOG2    (4),
    .RTS_THRESHOLD (RTS_TH)
  ) u_dut (
    .clk_int      (clk_int),
    .uart_reset   (uart_reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .flush        (flush)
`ifdef UART_RX_FIFO_RTS_EN
    ,
    .rts_n        (rts_n)
`endif
  );

  initial clk_int = 1'b0;
  always #5 clk_int = ~clk_int;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all(input string tag);
    logic [7:0] exp_d;
    exp_d = (q.size() != 0) ? q[0] : 8'h00;
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, ".data"}, 32'(out_data), 32'(exp_d));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_RTS_EN
    chk({tag, ".rts"}, 32'(rts_n), 32'(q.size() >= RTS_TH));
`endif
  endtask

  // Called at a falling edge; applies inputs for one rising edge.
  task automatic step(input logic v, input logic [7:0] d,
                      input logic rdy, input logic fl,
                      input logic clr, input string tag);
    bit full, pop;
    rx_valid     = v;
    rx_data      = d;
    out_ready    = rdy;
    flush        = fl;
    clr_overflow = clr;
    full = (q.size() == DEPTH);
    pop  = (q.size() != 0) && rdy;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (v && (!full || pop)) q.push_back(d);
    end
    if (!fl && v && full && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk_int);
    @(negedge clk_int);
    rx_valid     = 1'b0;
    out_ready    = 1'b0;
    flush        = 1'b0;
    clr_overflow = 1'b0;
    cmp_all(tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".level"}, 32'(level), 32'd0);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".data"}, 32'(out_data), 32'h00);
    chk({tag, ".ovf"}, 32'(overflow), 32'd0);
`ifdef UART_RX_FIFO_RTS_EN
    chk({tag, ".rts"}, 32'(rts_n), 32'd0);
`endif
  endtask

  initial begin
    uart_reset   = 1'b0;
    rx_data      = 8'h00;
    rx_valid     = 1'b0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    flush        = 1'b0;
    m_ovf        = 1'b0;
    @(negedge clk_int);
    @(negedge clk_int);
    uart_reset = 1'b1;
    chk_reset_vals("rst");

    // Two pushes, then two pops.
    step(1, 8'hA5, 0, 0, 0, "p0");
    step(1, 8'h3C, 0, 0, 0, "p1");
    chk("two.level", 32'(level), 32'd2);
    chk("two.head", 32'(out_data), 32'hA5);
    step(0, 8'h00, 1, 0, 0, "r0");
    chk("two.next", 32'(out_data), 32'h3C);
    step(0, 8'h00, 1, 0, 0, "r1");
    chk("two.empty", 32'(out_data), 32'h00);

    // Fill, overflow, drain, clear.
    for (int i = 0; i < 16; i++)
      step(1, 8'(i), 0, 0, 0, "fill");
    step(1, 8'hFF, 0, 0, 0, "drop");
    chk("ovf.set", 32'(overflow), 32'd1);
    chk("ovf.level", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain.order", 32'(out_data), 32'(i));
      step(0, 8'h00, 1, 0, 0, "drain");
    end
    step(0, 8'h00, 0, 0, 1, "clr");
    chk("ovf.clr", 32'(overflow), 32'd0);

    // Push and pop together while full.
    for (int i = 0; i < 16; i++)
      step(1, 8'(8'h10 + i), 0, 0, 0, "fill2");
    step(1, 8'h77, 1, 0, 0, "pushpop");
    chk("pp.ovf", 32'(overflow), 32'd0);
    chk("pp.level", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("pp.last", 32'(out_data), 32'h77);
      step(0, 8'h00, 1, 0, 0, "drain2");
    end

    // Streaming with pointer wrap.
    for (int i = 0; i < 120; i++) begin
      step((i % 3) == 0, 8'(8'hC0 + i / 3), 1, 0, 0, "wrap");
      chk("wrap.lvl_le1", 32'(level <= 5'd1), 32'd1);
    end

    // Flush with a same-cycle push.
    for (int i = 0; i < 5; i++)
      step(1, 8'(8'h40 + i), 0, 0, 0, "load5");
    step(1, 8'h55, 1, 1, 0, "flush");
    chk("flush.level", 32'(level), 32'd0);
    chk("flush.valid", 32'(out_valid), 32'd0);
    step(1, 8'h66, 0, 0, 0, "postflush");
    chk("flush.nodata55", 32'(out_data), 32'h66);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++)
      step(1, 8'(8'h90 + i), 0, 0, 0, "prerst");
    #2 uart_reset = 1'b0;
    #1 chk_reset_vals("arst");
    q.delete();
    m_ovf = 1'b0;
    @(negedge clk_int);
    uart_reset = 1'b1;
    cmp_all("arst.rel");

`ifdef UART_RX_FIFO_RTS_EN
    for (int i = 0; i < 11; i++)
      step(1, 8'(i), 0, 0, 0, "rts.fill");
    chk("rts.at11", 32'(rts_n), 32'd0);
    step(1, 8'hEE, 0, 0, 0, "rts.p12");
    chk("rts.at12", 32'(rts_n), 32'd1);
    step(0, 8'h00, 1, 0, 0, "rts.pop");
    chk("rts.pop", 32'(rts_n), 32'd0);
    step(0, 8'h00, 0, 1, 0, "rts.flush");
`endif

    // Randomized phases with varying consumer throughput.
    for (int ph = 0; ph < 4; ph++) begin
      int rdy_pct;
      rdy_pct = (ph == 0) ? 10 : (ph == 1) ? 50 : (ph == 2) ? 90 : 30;
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(0, 1) == 1,
             8'($urandom),
             $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 63) == 0,
             $urandom_range(0, 31) == 0,
             "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART receiver.
- Captures each byte the receiver flags with its single-cycle valid pulse and stores it in a circular FIFO.
- Presents bytes to the consumer (command logic or loopback to the transmitter) over a valid/ready handshake.
- Reports fill level and a sticky overflow flag, so bytes arriving at 4 Mbaud are not lost while the consumer is busy.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries); legal range 1..8.
- RTS_THRESHOLD, 12, level at or above which rts_n deasserts (see Optional Feature); must be in 1..2**DEPTH_LOG2.

Ports:
- clk_int  input  1  system clock; all logic on the rising edge.
- uart_reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte from the UART receiver.
- rx_valid  input  1  one-cycle pulse: rx_data holds a new byte.
- out_data  output  8  byte at the FIFO head.
- out_valid  output  1  out_data holds a buffered byte.
- out_ready  input  1  consumer accepts the head byte this cycle.
- level  output  DEPTH_LOG2+1  number of stored bytes, 0..2**DEPTH_LOG2.
- overflow  output  1  sticky; a byte was dropped because the FIFO was full.
- clr_overflow  input  1  synchronous clear of overflow.
- flush  input  1  synchronous discard of all stored bytes.
- rts_n  output  1  present only with UART_RX_FIFO_RTS_EN; active-low ready-to-send.

Behaviour:
- Clocking and reset: one clock, clk_int. uart_reset is asynchronous, active-low.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, out_valid=0, out_data=8'h00, overflow=0, rts_n=0.
- Storage array is not reset.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo 2**DEPTH_LOG2. level is a separate counter; full when level==2**DEPTH_LOG2, empty when level==0.
- push = rx_valid and (not full, or pop this cycle). The byte is written at wr_ptr, then wr_ptr increments.
- pop = out_valid and out_ready. rd_ptr increments.
- level update: +1 on push only, -1 on pop only, unchanged on both.
- Push and pop in the same cycle while full: the write is accepted, level stays at full, and no overflow occurs.
- Push while empty: the new byte is not poppable the same cycle (out_valid=0). The FIFO is first-word-fall-through with one cycle of latency: a byte pushed at edge N has out_valid=1 and out_data=byte after edge N.
- out_valid = (level != 0), derived from registered state. out_data = mem[rd_ptr] when out_valid, otherwise 8'h00.
- out_data is stable while out_valid=1 and out_ready=0.
- Drop rule: rx_valid while full and no pop means the byte is discarded, overflow is set, and pointers and level are unchanged.
- overflow stays set until clr_overflow. If a set event and clr_overflow occur in the same cycle, set wins.
- flush: pointers and level go to 0 at the next edge. flush has priority over a same-cycle push or pop; that byte is discarded but does not set overflow. flush does not clear overflow.
- rx_valid held high for several cycles counts as one push per cycle. The upstream receiver guarantees single-cycle pulses.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronous). Buffered bytes are lost.

Optional Feature:
- Macro: UART_RX_FIFO_RTS_EN.
- Defined:
  - Adds port rts_n, registered.
  - rts_n=1 (stop sender) when the next-cycle level is >= RTS_THRESHOLD, otherwise 0. It updates on the same edge as level.
  - After flush, rts_n=0.
- Not defined: port rts_n is absent, with no threshold logic. RTS_THRESHOLD is accepted but ignored.

Test Plan:
- Reset, then push 0xA5, 0x3C on consecutive cycles with out_ready=0 -> level=2, out_valid=1, out_data=0xA5. Then assert out_ready for 2 cycles -> reads 0xA5 then 0x3C, level=0, out_valid=0, out_data=0x00.
- Push 16 bytes 0x00..0x0F, then push 0xFF with out_ready=0 -> level=16, overflow=1, 0xFF absent. Drain yields 0x00..0x0F in order. Pulse clr_overflow -> overflow=0.
- With the FIFO full, push 0x77 and pop in the same cycle -> overflow stays 0, level=16, and 0x77 is the last byte read out after the remaining 15.
- Write and read 40 bytes continuously (out_ready=1, rx_valid every 3rd cycle) -> pointers wrap twice, output sequence identical, level never exceeds 1.
- Load 5 bytes, assert flush together with rx_valid (0x55) -> level=0, out_valid=0, overflow unchanged, 0x55 not stored. Assert uart_reset low mid-stream -> all outputs take reset values without a clock edge.
- With UART_RX_FIFO_RTS_EN and RTS_THRESHOLD=12: push 11 bytes -> rts_n=0. The 12th push -> rts_n=1 after that edge. One pop -> rts_n=0.
